// File: rtl/fpu_lib.sv
// fpu_lib: shared types and constants for the fp16 multiplier arbiter. Rev 1.0
`default_nettype none

package fpu_lib;

  typedef logic [15:0] fp16_t;
  typedef logic [3:0]  condCode_t;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_CLEAR = 3'd1,
    ARB_START = 3'd2,
    ARB_BUSY  = 3'd3,
    ARB_RESP  = 3'd4
  } fpuMulArbState_t;

  localparam int    FPU_MUL_ARB_TIMEOUT_DEFAULT = 64;
  localparam fp16_t FP16_QNAN                   = 16'h7E00;

endpackage

`default_nettype wire

// File: rtl/fpu_mul_arb_rr.sv
// fpuRRArbiter: one-hot round-robin pick, searching upward from pointer with wrap. Rev 1.0
`default_nettype none

module fpuRRArbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin : p_search
    int   cand;
    logic found;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(pointer) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        winner[cand[IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_mul_arb.sv
// fpu_mul_arb: shares one fpuMul16 among NUM_REQ requesters, one op at a time. Rev 1.0
// Optional busy-cycle abort returning quiet NaN: define FPU_MUL_ARB_TIMEOUT_EN.
`default_nettype none

module fpu_mul_arb
  import fpu_lib::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = FPU_MUL_ARB_TIMEOUT_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  fp16_t [NUM_REQ-1:0] reqIn1,
  input  fp16_t [NUM_REQ-1:0] reqIn2,
  output logic [NUM_REQ-1:0]  grant,
  output logic [NUM_REQ-1:0]  respValid,
  output fp16_t               respOut,
  output condCode_t           respCondCodes,
  output logic                respTimeout,
  output fp16_t               mulIn1,
  output fp16_t               mulIn2,
  output logic                mulStart,
  output logic                mulClear,
  input  fp16_t               mulOut,
  input  condCode_t           mulCondCodes,
  input  logic                mulDone
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fpu_mul_arb: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("fpu_mul_arb: TIMEOUT_CYC must be at least 1");
  end

  fpuMulArbState_t    state, state_next;
  logic [IDX_W-1:0]   ptr, cur_idx, win_idx;
  logic [NUM_REQ-1:0] winner;
  logic               take;
  logic               timed_out;

  fpuRRArbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req),
    .pointer (ptr),
    .winner  (winner)
  );

  assign take = (state == ARB_IDLE) && (|req);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = IDX_W'(i);
    end
  end

`ifdef FPU_MUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] busy_cnt;
  logic             timeout_flag;

  // busy_cnt equals the number of ARB_BUSY cycles already spent
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   busy_cnt <= '0;
    else if (state == ARB_BUSY)  busy_cnt <= busy_cnt + 1'b1;
    else                         busy_cnt <= '0;
  end

  assign timed_out = (state == ARB_BUSY) && !mulDone &&
                     (busy_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                        timeout_flag <= 1'b0;
    else if ((state == ARB_BUSY) && (mulDone || timed_out)) timeout_flag <= timed_out;
  end

  assign respTimeout = timeout_flag && (state == ARB_RESP);
`else
  assign timed_out   = 1'b0;
  assign respTimeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = '0;
    respValid  = '0;
    mulStart   = 1'b0;
    mulClear   = reset;
    case (state)
      ARB_IDLE: begin
        if (take) begin
          grant      = winner & {NUM_REQ{!reset}};
          state_next = ARB_CLEAR;
        end
      end
      ARB_CLEAR: begin
        mulClear   = 1'b1;
        state_next = ARB_START;
      end
      ARB_START: begin
        mulStart   = 1'b1;
        state_next = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (mulDone || timed_out) state_next = ARB_RESP;
      end
      ARB_RESP: begin
        respValid  = NUM_REQ'(1) << cur_idx;
        state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr           <= '0;
      cur_idx       <= '0;
      mulIn1        <= '0;
      mulIn2        <= '0;
      respOut       <= '0;
      respCondCodes <= '0;
    end else begin
      if (take) begin
        cur_idx <= win_idx;
        mulIn1  <= reqIn1[win_idx];
        mulIn2  <= reqIn2[win_idx];
        ptr     <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      // a real result wins over a timeout landing in the same cycle
      if (state == ARB_BUSY) begin
        if (mulDone) begin
          respOut       <= mulOut;
          respCondCodes <= mulCondCodes;
        end else if (timed_out) begin
          respOut       <= FP16_QNAN;
          respCondCodes <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_mul_arb.sv
// tb_fpu_mul_arb: self-checking bench for fpu_mul_arb with a behavioural fp16 multiplier. Rev 1.0
`default_nettype none

module tb_fpu_mul_arb;
  import fpu_lib::*;

  localparam int N   = 4;
  localparam int TMO = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  fp16_t [N-1:0] reqIn1, reqIn2;
  logic [N-1:0]  grant, respValid;
  fp16_t         respOut, mulIn1, mulIn2;
  fp16_t         mulOut = '0;
  condCode_t     respCondCodes;
  condCode_t     mulCondCodes = '0;
  logic          respTimeout, mulStart, mulClear, mulDone;
  logic          done_model = 1'b0;
  logic          inject = 1'b0;

  fpu_mul_arb #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .reqIn1        (reqIn1),
    .reqIn2        (reqIn2),
    .grant         (grant),
    .respValid     (respValid),
    .respOut       (respOut),
    .respCondCodes (respCondCodes),
    .respTimeout   (respTimeout),
    .mulIn1        (mulIn1),
    .mulIn2        (mulIn2),
    .mulStart      (mulStart),
    .mulClear      (mulClear),
    .mulOut        (mulOut),
    .mulCondCodes  (mulCondCodes),
    .mulDone       (mulDone)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // normal-number fp16 multiply, truncating
  function automatic fp16_t fmul(input fp16_t a, input fp16_t b);
    logic [21:0] p;
    logic [5:0]  e;
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = 6'(a[14:10]) + 6'(b[14:10]) - 6'd15;
    if (p[21]) return {a[15] ^ b[15], e[4:0] + 5'd1, p[20:11]};
    else       return {a[15] ^ b[15], e[4:0], p[19:10]};
  endfunction

  // multiplier model: mulDone rises mul_lat cycles after the mulStart cycle
  int    mul_lat  = 3;
  bit    mul_dead = 1'b0;
  int    m_cnt    = 0;
  fp16_t m_a, m_b;
  always @(posedge clock) begin
    if (mulClear) begin
      done_model <= 1'b0;
      m_cnt      <= 0;
    end else if (mulStart) begin
      m_a   <= mulIn1;
      m_b   <= mulIn2;
      m_cnt <= mul_dead ? 0 : mul_lat - 1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        done_model   <= 1'b1;
        mulOut       <= fmul(m_a, m_b);
        mulCondCodes <= m_a[3:0] ^ m_b[3:0];
      end
    end
  end
  assign mulDone = done_model | inject;

  typedef struct {
    int        idx;
    fp16_t     a;
    fp16_t     b;
    fp16_t     out;
    condCode_t cc;
    logic      to;
  } exp_t;

  exp_t      sb[$];
  fp16_t     exp_out[N];
  condCode_t exp_cc[N];
  logic      exp_to[N];
  int        grant_log[$];
  int        grant_cyc[$];
  int        cyc = 0, resp_cnt = 0, resp_cyc = 0, start_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    int   gi;
    exp_t e;
    if (!reset) begin
      if (grant != '0) begin
        chk("grant_onehot", 32'($onehot(grant)), 1);
        gi = 0;
        for (int i = 0; i < N; i++) if (grant[i]) gi = i;
        grant_log.push_back(gi);
        grant_cyc.push_back(cyc);
        e.idx = gi; e.a = reqIn1[gi]; e.b = reqIn2[gi];
        e.out = exp_out[gi]; e.cc = exp_cc[gi]; e.to = exp_to[gi];
        sb.push_back(e);
      end
      if (mulStart) begin
        start_cyc = cyc;
        if (sb.size() == 0) chk("start_without_grant", sb.size(), 1);
        else begin
          chk("mul_in1", mulIn1, sb[0].a);
          chk("mul_in2", mulIn2, sb[0].b);
        end
      end
      if (respValid != '0) begin
        if (sb.size() == 0) chk("resp_unexpected", respValid, 0);
        else begin
          e = sb.pop_front();
          chk("resp_idx", respValid, 1 << e.idx);
          chk("resp_out", respOut, e.out);
          chk("resp_cc", respCondCodes, e.cc);
          chk("resp_timeout", respTimeout, e.to);
        end
        resp_cnt++;
        resp_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input int i, input fp16_t a, input fp16_t b, input fp16_t p, input logic to);
    reqIn1[i]  = a;
    reqIn2[i]  = b;
    exp_out[i] = p;
    exp_cc[i]  = to ? 4'h0 : (a[3:0] ^ b[3:0]);
    exp_to[i]  = to;
    req[i]     = 1'b1;
  endtask

  task automatic wait_grants(input int target, input string name);
    int k = 0;
    while (grant_log.size() < target && k < 200) begin
      tick(1);
      k++;
    end
    chk(name, grant_log.size(), target);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      tick(1);
      k++;
    end
    chk(name, sb.size(), 0);
  endtask

  typedef struct {
    int    idx;
    fp16_t a;
    fp16_t b;
    fp16_t p;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   g0, rc;
    vt[0] = '{0, 16'h3C00, 16'h4000, 16'h4000};
    vt[1] = '{1, 16'h4000, 16'h4000, 16'h4400};
    vt[2] = '{2, 16'h3E00, 16'h3E00, 16'h4080};
    vt[3] = '{3, 16'hC000, 16'h3800, 16'hBC00};
    vt[4] = '{1, 16'h4200, 16'h4500, 16'h4B80};
    vt[5] = '{2, 16'h3555, 16'h3C00, 16'h3555};

    reset  = 1'b1;
    req    = '0;
    reqIn1 = '0;
    reqIn2 = '0;
    for (int i = 0; i < N; i++) begin
      exp_out[i] = '0; exp_cc[i] = '0; exp_to[i] = 1'b0;
    end
    req[0] = 1'b1;
    tick(3);
    chk("rst_grant", grant, 0);
    chk("rst_respValid", respValid, 0);
    chk("rst_respOut", respOut, 0);
    chk("rst_respCC", respCondCodes, 0);
    chk("rst_respTimeout", respTimeout, 0);
    chk("rst_mulIn1", mulIn1, 0);
    chk("rst_mulIn2", mulIn2, 0);
    chk("rst_mulStart", mulStart, 0);
    chk("rst_mulClear", mulClear, 1);
    req   = '0;
    reset = 1'b0;
    tick(2);

    for (int v = 0; v < 6; v++) begin
      mul_lat = 2 + (v % 3);
      g0 = grant_log.size();
      issue(vt[v].idx, vt[v].a, vt[v].b, vt[v].p, 1'b0);
      wait_grants(g0 + 1, "vec_grant");
      req = '0;
      wait_drain("vec_resp");
      chk("vec_single_grant", grant_log.size(), g0 + 1);
      if (grant_log.size() > g0) begin
        chk("vec_grant_idx", grant_log[g0], vt[v].idx);
        chk("vec_latency", resp_cyc - grant_cyc[g0], mul_lat + 3);
      end
      tick(1);
    end

    // two held requesters from reset alternate 0,3,0,3
    reset = 1'b1;
    tick(2);
    reset   = 1'b0;
    mul_lat = 3;
    tick(1);
    g0 = grant_log.size();
    issue(0, 16'h3C00, 16'h4000, 16'h4000, 1'b0);
    issue(3, 16'h4200, 16'h4500, 16'h4B80, 1'b0);
    wait_grants(g0 + 4, "rr_grants");
    req = '0;
    wait_drain("rr_resp");
    if (grant_log.size() >= g0 + 4) begin
      chk("rr_order0", grant_log[g0],     0);
      chk("rr_order1", grant_log[g0 + 1], 3);
      chk("rr_order2", grant_log[g0 + 2], 0);
      chk("rr_order3", grant_log[g0 + 3], 3);
      for (int k = 1; k < 4; k++)
        chk("rr_spacing", grant_cyc[g0 + k] - grant_cyc[g0 + k - 1], 4 + mul_lat);
    end
    tick(2);

    // request arriving while busy waits for the current response
    mul_lat = 6;
    g0 = grant_log.size();
    issue(0, 16'h4000, 16'h4000, 16'h4400, 1'b0);
    wait_grants(g0 + 1, "hold_first");
    req[0] = 1'b0;
    tick(2);
    issue(2, 16'h3E00, 16'h3E00, 16'h4080, 1'b0);
    wait_grants(g0 + 2, "hold_second");
    req = '0;
    if (grant_log.size() >= g0 + 2) begin
      chk("hold_idx", grant_log[g0 + 1], 2);
      chk("hold_after_resp", grant_cyc[g0 + 1] - resp_cyc, 1);
      chk("hold_spacing", grant_cyc[g0 + 1] - grant_cyc[g0], 4 + mul_lat);
    end
    wait_drain("hold_resp");
    tick(2);

    // reset in the middle of a busy wait
    mul_lat = 8;
    g0 = grant_log.size();
    issue(1, 16'h4000, 16'h4000, 16'h4400, 1'b0);
    wait_grants(g0 + 1, "abort_grant");
    req = '0;
    tick(3);
    reset = 1'b1;
    #1;
    chk("abort_grant0", grant, 0);
    chk("abort_respValid", respValid, 0);
    chk("abort_respOut", respOut, 0);
    chk("abort_respCC", respCondCodes, 0);
    chk("abort_respTimeout", respTimeout, 0);
    chk("abort_mulIn1", mulIn1, 0);
    chk("abort_mulIn2", mulIn2, 0);
    chk("abort_mulStart", mulStart, 0);
    chk("abort_mulClear", mulClear, 1);
    rc = resp_cnt;
    sb.delete();
    tick(2);
    reset = 1'b0;
    tick(12);
    chk("abort_no_resp", resp_cnt, rc);

    // stray mulDone in idle is ignored
    mul_lat = 3;
    g0 = grant_log.size();
    inject = 1'b1;
    tick(1);
    inject = 1'b0;
    tick(4);
    chk("inject_no_resp", resp_cnt, rc);
    chk("inject_no_grant", grant_log.size(), g0);

    // pointer restarted at 0: requester 0 beats 3
    issue(0, 16'hC000, 16'h3800, 16'hBC00, 1'b0);
    issue(3, 16'h3555, 16'h3C00, 16'h3555, 1'b0);
    wait_grants(g0 + 1, "post_reset_grant");
    req = '0;
    if (grant_log.size() > g0) chk("post_reset_ptr", grant_log[g0], 0);
    wait_drain("post_reset_resp");
    tick(2);

`ifdef FPU_MUL_ARB_TIMEOUT_EN
    mul_dead = 1'b1;
    g0 = grant_log.size();
    issue(3, 16'h4000, 16'h4000, FP16_QNAN, 1'b1);
    wait_grants(g0 + 1, "tmo_grant");
    req = '0;
    wait_drain("tmo_resp");
    chk("tmo_latency", resp_cyc - (start_cyc + 1), TMO);
    mul_dead = 1'b0;
    tick(2);
    g0 = grant_log.size();
    issue(2, 16'h4200, 16'h4500, 16'h4B80, 1'b0);
    wait_grants(g0 + 1, "tmo_recover_grant");
    req = '0;
    wait_drain("tmo_recover_resp");
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d failures so far", fails);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
